codificador_instrucao: RTL and testbench

- Inverse of the instruction decoder: takes MIPS instruction fields plus an instruction class and packs them into 32-bit instruction words.
- Encoded words are buffered in a small FIFO. Each word is tagged with a sequential word address, ready for writing into instruction memory.
- Sits between the test/program loader and the instruction memory.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/codificador_instrucao_fifo_sinc.sv | 85 ++++++++
 rtl/codificador_instrucao.sv | 113 +++++++++++
 tb/tb_codificador_instrucao.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants used by both the instruction encoder and decoder.
// Holds opcodes, instruction classes (tipo) and R-type function codes.
package mips_pkg;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;

    typedef enum logic [2:0] {
        TIPO_R   = 3'd0,
        TIPO_J   = 3'd1,
        TIPO_LW  = 3'd2,
        TIPO_SW  = 3'd3,
        TIPO_BEQ = 3'd4
    } tipo_e;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2a;

    function automatic logic tipo_valido(input logic [2:0] t);
        return t <= TIPO_BEQ;
    endfunction

endpackage

// File: rtl/codificador_instrucao_fifo_sinc.sv
// Synchronous shift-style FIFO whose head entry is a dedicated register, so the
// output is always registered and has a defined value after reset.
module fifo_sinc #(
    parameter int                 DATA_W    = 40,
    parameter int                 DEPTH     = 4,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0,
    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int                OCC_W     = IDX_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [OCC_W-1:0]  occupancy
);

    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] body [1:DEPTH-1];
    logic [DATA_W-1:0] cur  [DEPTH];
    logic [DATA_W-1:0] nxt  [DEPTH];
    logic [OCC_W-1:0]  occ, occ_nxt;
    logic [IDX_W-1:0]  wr_idx;
    logic              do_push, do_pop;

    assign full      = (occ == OCC_W'(DEPTH));
    assign empty     = (occ == '0);
    assign occupancy = occ;
    assign dout      = head;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // A same-cycle pop shifts everything down one slot, so the write lands one lower.
    assign wr_idx  = do_pop ? IDX_W'(occ - 1'b1) : IDX_W'(occ);

    always_comb begin
        cur[0] = head;
        for (int i = 1; i < DEPTH; i++) cur[i] = body[i];
    end

    // Only occupied slots shift, so an emptied head keeps its last word.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) nxt[i] = cur[i];
        if (!clr) begin
            if (do_pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    if (OCC_W'(i + 1) < occ) nxt[i] = cur[i + 1];
                end
            end
            if (do_push) nxt[wr_idx] = din;
        end
    end

    always_comb begin
        occ_nxt = occ;
        if (clr) begin
            occ_nxt = '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   occ_nxt = occ + 1'b1;
                2'b01:   occ_nxt = occ - 1'b1;
                default: occ_nxt = occ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) occ <= '0;
        else       occ <= occ_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) head <= RESET_VAL;
        else       head <= nxt[0];
    end

    always_ff @(posedge clk) begin
        for (int i = 1; i < DEPTH; i++) body[i] <= nxt[i];
    end

endmodule

// File: rtl/codificador_instrucao.sv
// MIPS instruction encoder: packs fields by class into 32-bit words, tags each with
// a sequential word address and buffers them for the instruction-memory writer.
module codificador_instrucao
    import mips_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int BASE_ADDR  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              limpa,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        tipo,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       address,
    input  logic [25:0]       addressJ,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       instrucao,
    output logic [ADDR_W-1:0] out_addr,
    output logic              erro,
    output logic [ADDR_W:0]   contagem
);

    localparam int                DATA_W = ADDR_W + 32;
    localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);
    localparam int                OCC_W  = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;

    function automatic logic [31:0] codifica(
        input logic [2:0]  t,
        input logic [4:0]  f_rs,
        input logic [4:0]  f_rt,
        input logic [4:0]  f_rd,
        input logic [4:0]  f_shamt,
        input logic [5:0]  f_funct,
        input logic [15:0] f_imm,
        input logic [25:0] f_alvo
    );
        logic [31:0] w;
        w = '0;
        case (tipo_e'(t))
            TIPO_R:   w = {OP_R, f_rs, f_rt, f_rd, f_shamt, f_funct};
            TIPO_J:   w = {OP_J, f_alvo};
            TIPO_LW:  w = {OP_LW, f_rs, f_rt, f_imm};
            TIPO_SW:  w = {OP_SW, f_rs, f_rt, f_imm};
            TIPO_BEQ: w = {OP_BEQ, f_rs, f_rt, f_imm};
            default:  w = '0;
        endcase
        return w;
    endfunction

    logic [31:0]       palavra;
    logic [ADDR_W-1:0] contador;
    logic              aceita, tipo_ok, push, pop;
    logic              full, empty;
    logic [OCC_W-1:0]  ocupacao_unused;
    logic [DATA_W-1:0] cabeca;

    assign palavra  = codifica(tipo, rs, rt, rd, shamt, funct, address, addressJ);
    assign tipo_ok  = tipo_valido(tipo);

    assign in_ready  = !full;
    assign out_valid = !empty;
    // An invalid class still completes the handshake; it just never reaches the FIFO.
    assign aceita    = in_valid && in_ready;
    assign push      = aceita && tipo_ok && !limpa;
    assign pop       = out_valid && out_ready;

    assign instrucao = cabeca[31:0];
    assign out_addr  = cabeca[DATA_W-1:32];

    fifo_sinc #(
        .DATA_W    (DATA_W),
        .DEPTH     (FIFO_DEPTH),
        .RESET_VAL ({BASE, 32'h0})
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clr       (limpa),
        .push      (push),
        .pop       (pop),
        .din       ({contador, palavra}),
        .dout      (cabeca),
        .full      (full),
        .empty     (empty),
        .occupancy (ocupacao_unused)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     contador <= BASE;
        else if (limpa) contador <= BASE;
        else if (push)  contador <= contador + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  erro <= 1'b0;
        else if (limpa)             erro <= 1'b0;
        else if (aceita && !tipo_ok) erro <= 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                         contagem <= '0;
        else if (limpa)                    contagem <= '0;
        else if (pop && (contagem != '1))  contagem <= contagem + 1'b1;
    end

endmodule

// File: tb/tb_codificador_instrucao.sv
// Self-checking bench for codificador_instrucao: directed scenarios plus random
// traffic, checked every cycle against a queue-based reference model.
module tb_codificador_instrucao;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        limpa = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  tipo = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
    logic [5:0]  funct = '0;
    logic [15:0] address = '0;
    logic [25:0] addressJ = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] instrucao;
    logic [7:0]  out_addr;
    logic        erro;
    logic [8:0]  contagem;

    codificador_instrucao #(.ADDR_W(8), .FIFO_DEPTH(4), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .limpa(limpa),
        .in_valid(in_valid), .in_ready(in_ready),
        .tipo(tipo), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .address(address), .addressJ(addressJ),
        .out_valid(out_valid), .out_ready(out_ready),
        .instrucao(instrucao), .out_addr(out_addr),
        .erro(erro), .contagem(contagem)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] w; logic [7:0] a; } ent_t;
    ent_t        q[$];
    int          m_cnt;
    int          m_cont;
    logic        m_erro;
    logic [31:0] m_head_w;
    logic [7:0]  m_head_a;
    int          n_tests = 0;
    int          n_fail  = 0;

    localparam longint P26 = 67108864;
    localparam longint P21 = 2097152;
    localparam longint P16 = 65536;
    localparam longint P11 = 2048;

    function automatic logic [31:0] ref_enc();
        longint v;
        case (tipo)
            3'd0: v = rs * P21 + rt * P16 + rd * P11 + shamt * 64 + funct;
            3'd1: v = 2 * P26 + addressJ;
            3'd2: v = 35 * P26 + rs * P21 + rt * P16 + address;
            3'd3: v = 43 * P26 + rs * P21 + rt * P16 + address;
            default: v = 4 * P26 + rs * P21 + rt * P16 + address;
        endcase
        return v[31:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() != 0));
        check({tag, ".in_ready"},  64'(in_ready),  64'(q.size() < 4));
        check({tag, ".instrucao"}, 64'(instrucao), 64'(m_head_w));
        check({tag, ".out_addr"},  64'(out_addr),  64'(m_head_a));
        check({tag, ".erro"},      64'(erro),      64'(m_erro));
        check({tag, ".contagem"},  64'(contagem),  64'(m_cont));
    endtask

    task automatic tick(input string tag);
        bit pop, acc;
        @(posedge clk);
        if (limpa) begin
            q.delete();
            m_cnt  = 0;
            m_cont = 0;
            m_erro = 1'b0;
        end else begin
            pop = out_ready && (q.size() > 0);
            acc = in_valid && (q.size() < 4);
            if (pop) begin
                void'(q.pop_front());
                if (m_cont < 511) m_cont++;
            end
            if (acc) begin
                if (tipo <= 3'd4) begin
                    q.push_back('{w: ref_enc(), a: 8'(m_cnt)});
                    m_cnt = (m_cnt + 1) % 256;
                end else begin
                    m_erro = 1'b1;
                end
            end
        end
        if (q.size() > 0) begin
            m_head_w = q[0].w;
            m_head_a = q[0].a;
        end
        #1;
        check_all(tag);
    endtask

    // Reset lands mid-cycle so its effect is observed before any clock edge.
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        limpa = 1'b0;
        q.delete();
        m_cnt = 0; m_cont = 0; m_erro = 1'b0;
        m_head_w = '0; m_head_a = '0;
        #1;
        check_all({tag, ".async"});
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_all({tag, ".rel"});
    endtask

    task automatic rand_fields(input logic [2:0] t);
        tipo = t;
        rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
        shamt = 5'($urandom); funct = 6'($urandom);
        address = 16'($urandom); addressJ = 26'($urandom);
    endtask

    initial begin
        logic [31:0] exp_w [4];

        // 1: single R-type word
        do_reset("t1");
        tipo = 3'd0; rs = 5'd2; rt = 5'd3; rd = 5'd1; shamt = 5'd0; funct = 6'h20;
        in_valid = 1'b1; out_ready = 1'b1;
        tick("t1.push");
        in_valid = 1'b0;
        check("t1.word", 64'(instrucao), 64'h00430820);
        check("t1.addr", 64'(out_addr), 64'h00);
        tick("t1.pop");
        check("t1.contagem", 64'(contagem), 64'd1);

        // 2: LW, SW, BEQ, J back-to-back
        do_reset("t2");
        in_valid = 1'b1;
        tipo = 3'd2; rs = 5'd9; rt = 5'd8; address = 16'd4; tick("t2.lw");
        tipo = 3'd3; tick("t2.sw");
        tipo = 3'd4; rs = 5'd1; rt = 5'd2; address = 16'hFFFF; tick("t2.beq");
        tipo = 3'd1; addressJ = 26'h0100000; tick("t2.j");
        in_valid = 1'b0;
        exp_w[0] = 32'h8D280004; exp_w[1] = 32'hAD280004;
        exp_w[2] = 32'h1022FFFF; exp_w[3] = 32'h08100000;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2.word%0d", i), 64'(instrucao), 64'(exp_w[i]));
            check($sformatf("t2.addr%0d", i), 64'(out_addr), 64'(i));
            tick("t2.drain");
        end
        check("t2.empty", 64'(out_valid), 64'd0);

        // 3: backpressure with a full FIFO
        do_reset("t3");
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rand_fields(3'($urandom_range(0, 4)));
            tick("t3.fill");
        end
        check("t3.full", 64'(in_ready), 64'd0);
        rand_fields(3'd0);
        tick("t3.wait");
        out_ready = 1'b1;
        tick("t3.pulse");
        out_ready = 1'b0;
        tick("t3.fifth");
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick("t3.drain");

        // 4: invalid tipo between two R words
        do_reset("t4");
        in_valid = 1'b1;
        rand_fields(3'd0); tick("t4.r0");
        rand_fields(3'd6); tick("t4.bad");
        rand_fields(3'd0); tick("t4.r1");
        in_valid = 1'b0;
        check("t4.erro", 64'(erro), 64'd1);
        out_ready = 1'b1;
        check("t4.addr0", 64'(out_addr), 64'd0);
        tick("t4.pop0");
        check("t4.addr1", 64'(out_addr), 64'd1);
        tick("t4.pop1");
        tick("t4.idle");
        check("t4.erro_sticky", 64'(erro), 64'd1);
        check("t4.count", 64'(contagem), 64'd2);

        // 5: address wrap and contagem saturation
        do_reset("t5");
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 255; i++) begin
            rand_fields(3'($urandom_range(0, 4)));
            tick("t5.preset");
        end
        in_valid = 1'b0;
        tick("t5.drain");
        out_ready = 1'b0; in_valid = 1'b1;
        rand_fields(3'd1); tick("t5.w255");
        rand_fields(3'd2); tick("t5.w256");
        in_valid = 1'b0;
        check("t5.addr_ff", 64'(out_addr), 64'hFF);
        out_ready = 1'b1;
        tick("t5.pop");
        check("t5.addr_00", 64'(out_addr), 64'h00);
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rand_fields(3'($urandom_range(0, 4)));
            tick("t5.sat");
        end
        check("t5.contagem_sat", 64'(contagem), 64'h1FF);

        // 6: limpa with queued words and a same-cycle push, then reset mid-burst
        do_reset("t6");
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_fields(3'($urandom_range(0, 4)));
            tick("t6.fill");
        end
        rand_fields(3'd7); tick("t6.bad");
        rand_fields(3'd0);
        limpa = 1'b1; out_ready = 1'b1;
        tick("t6.limpa");
        limpa = 1'b0; out_ready = 1'b0;
        check("t6.ov", 64'(out_valid), 64'd0);
        check("t6.erro", 64'(erro), 64'd0);
        check("t6.cont", 64'(contagem), 64'd0);
        rand_fields(3'd3); tick("t6.push");
        check("t6.base", 64'(out_addr), 64'd0);
        rand_fields(3'd4); tick("t6.burst");
        do_reset("t6.reset");

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            limpa     = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 9) == 0) rand_fields(3'($urandom_range(5, 7)));
            else                           rand_fields(3'($urandom_range(0, 4)));
            tick("rand");
        end
        limpa = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
